change_payout: RTL and testbench

Coin payout controller on the return path of the vending machine: it accepts a change or refund amount and pays it out through a 10-rupee hopper and a 5-rupee hopper. It pays greedily (tens first) and confirms each coin with the chute sensor, with a timeout per coin. It tracks hopper inventory and reports completion, the amount actually paid, or an error code to the vending controller.

---
 rtl/change_payout_pkg.sv | 20 ++
 rtl/change_payout_hopper_pulse_timer.sv | 50 +++++
 rtl/change_payout.sv | 178 +++++++++++++++++
 tb/tb_change_payout.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/change_payout_pkg.sv
// Shared types and constants for the coin payout controller.
package change_payout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_EJECT,
    ST_WAIT,
    ST_FINISH,
    ST_FAULT
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_JAM   = 2'b10;

  localparam int TEN_UNITS  = 2;
  localparam int FIVE_UNITS = 1;

endpackage

// File: rtl/change_payout_hopper_pulse_timer.sv
// Eject pulse generator, coin-confirmation timeout counter and sticky coin flag,
// shared by both hoppers since only one coin is ever in flight.
module hopper_pulse_timer #(
  parameter int PULSE_LEN = 4,
  parameter int TIMEOUT   = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_eject,
  input  logic in_wait,
  input  logic coin_seen,
  output logic pulse_active,
  output logic confirmed,
  output logic timed_out
);

  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [PW-1:0] pulse_cnt_reg;
  logic [TW-1:0] wait_cnt_reg;
  logic          seen_reg;

  // pulse_cnt_reg holds the eject cycles remaining after the current one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
      seen_reg      <= 1'b0;
    end else begin
      if (start)
        pulse_cnt_reg <= PW'(PULSE_LEN - 1);
      else if (pulse_cnt_reg != '0)
        pulse_cnt_reg <= pulse_cnt_reg - 1'b1;

      wait_cnt_reg <= in_wait ? wait_cnt_reg + 1'b1 : '0;

      if (start)
        seen_reg <= 1'b0;
      else if (in_eject && coin_seen)
        seen_reg <= 1'b1;
    end
  end

  assign pulse_active = (pulse_cnt_reg != '0);
  assign confirmed    = in_wait && (seen_reg || coin_seen);
  assign timed_out    = in_wait && (TW'(wait_cnt_reg + 1'b1) == TW'(TIMEOUT));

endmodule

// File: rtl/change_payout.sv
// Greedy 10/5-rupee change payout with per-coin confirmation, timeout and
// hopper inventory tracking.
module change_payout
  import change_payout_pkg::*;
#(
  parameter int AMT_W     = 6,
  parameter int CNT_W     = 8,
  parameter int PULSE_LEN = 4,
  parameter int TIMEOUT   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             load,
  input  logic [CNT_W-1:0] load_tens,
  input  logic [CNT_W-1:0] load_fives,
  output logic             eject_ten,
  output logic             eject_five,
  input  logic             coin_seen,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [AMT_W-1:0] paid,
  output logic [CNT_W-1:0] tens_left,
  output logic [CNT_W-1:0] fives_left
);

  localparam int SW = ((AMT_W > CNT_W) ? AMT_W : CNT_W) + 1;

  state_t           state_reg, state_next;
  logic             sel_ten_reg, sel_ten_next;
  logic [AMT_W-1:0] rem_reg, rem_next;
  logic [AMT_W-1:0] paid_reg, paid_next;
  logic [CNT_W-1:0] tens_reg, tens_next;
  logic [CNT_W-1:0] fives_reg, fives_next;
  logic [1:0]       err_code_reg, err_code_next;
  logic             ready_reg, done_reg, err_reg;
  logic             eject_ten_reg, eject_five_reg;

  logic start, pulse_active, confirmed, timed_out;

  // Fives needed after using as many tens as possible
  logic [SW-1:0] half_ext, tens_ext, t_ext, need_ext;
  logic          short_inv;

  assign half_ext  = SW'(rem_reg >> 1);
  assign tens_ext  = SW'(tens_reg);
  assign t_ext     = (half_ext < tens_ext) ? half_ext : tens_ext;
  assign need_ext  = SW'(rem_reg) - (t_ext << 1);
  assign short_inv = (need_ext > SW'(fives_reg));

  hopper_pulse_timer #(
    .PULSE_LEN(PULSE_LEN),
    .TIMEOUT  (TIMEOUT)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_eject    (state_reg == ST_EJECT),
    .in_wait     (state_reg == ST_WAIT),
    .coin_seen   (coin_seen),
    .pulse_active(pulse_active),
    .confirmed   (confirmed),
    .timed_out   (timed_out)
  );

  always_comb begin
    state_next    = state_reg;
    sel_ten_next  = sel_ten_reg;
    rem_next      = rem_reg;
    paid_next     = paid_reg;
    tens_next     = tens_reg;
    fives_next    = fives_reg;
    err_code_next = err_code_reg;
    start         = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (load) begin
          tens_next  = load_tens;
          fives_next = load_fives;
        end
        if (req_valid) begin
          rem_next      = req_amount;
          paid_next     = '0;
          err_code_next = ERR_NONE;
          state_next    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rem_reg == '0) begin
          state_next = ST_FINISH;
        end else if (short_inv) begin
          err_code_next = ERR_SHORT;
          state_next    = ST_FAULT;
        end else begin
          sel_ten_next = (rem_reg >= AMT_W'(TEN_UNITS)) && (tens_reg != '0);
          start        = 1'b1;
          state_next   = ST_EJECT;
        end
      end
      ST_EJECT: begin
        if (!pulse_active)
          state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (confirmed) begin
          if (sel_ten_reg) begin
            rem_next  = rem_reg - AMT_W'(TEN_UNITS);
            paid_next = paid_reg + AMT_W'(TEN_UNITS);
            tens_next = tens_reg - 1'b1;
          end else begin
            rem_next   = rem_reg - AMT_W'(FIVE_UNITS);
            paid_next  = paid_reg + AMT_W'(FIVE_UNITS);
            fives_next = fives_reg - 1'b1;
          end
          state_next = ST_CHECK;
        end else if (timed_out) begin
          // A silent ten hopper is treated as empty; a silent five hopper is a jam
          if (sel_ten_reg) begin
            tens_next  = '0;
            state_next = ST_CHECK;
          end else begin
            fives_next    = '0;
            err_code_next = ERR_JAM;
            state_next    = ST_FAULT;
          end
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      ST_FAULT:  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      sel_ten_reg    <= 1'b0;
      rem_reg        <= '0;
      paid_reg       <= '0;
      tens_reg       <= '0;
      fives_reg      <= '0;
      err_code_reg   <= ERR_NONE;
      ready_reg      <= 1'b1;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      eject_ten_reg  <= 1'b0;
      eject_five_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_ten_reg    <= sel_ten_next;
      rem_reg        <= rem_next;
      paid_reg       <= paid_next;
      tens_reg       <= tens_next;
      fives_reg      <= fives_next;
      err_code_reg   <= err_code_next;
      ready_reg      <= (state_next == ST_IDLE);
      done_reg       <= (state_next == ST_FINISH);
      err_reg        <= (state_next == ST_FAULT);
      eject_ten_reg  <= (state_next == ST_EJECT) && sel_ten_next;
      eject_five_reg <= (state_next == ST_EJECT) && !sel_ten_next;
    end
  end

  assign req_ready  = ready_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign err_code   = err_code_reg;
  assign paid       = paid_reg;
  assign tens_left  = tens_reg;
  assign fives_left = fives_reg;
  assign eject_ten  = eject_ten_reg;
  assign eject_five = eject_five_reg;

endmodule

// File: tb/tb_change_payout.sv
// Scoreboard bench for change_payout: driver queues expected results, a monitor
// checks them on done/err, and a responder plays the chute sensor.
module tb_change_payout;

  localparam int AMT_W     = 6;
  localparam int CNT_W     = 8;
  localparam int PULSE_LEN = 4;
  localparam int TIMEOUT   = 1000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_ready;
  logic             load = 1'b0;
  logic [CNT_W-1:0] load_tens = '0;
  logic [CNT_W-1:0] load_fives = '0;
  logic             eject_ten, eject_five;
  logic             coin_seen;
  logic             coin_ack = 1'b0;
  logic             coin_force = 1'b0;
  logic             done, err;
  logic [1:0]       err_code;
  logic [AMT_W-1:0] paid;
  logic [CNT_W-1:0] tens_left, fives_left;
  logic [15:0]      skip_mask = '0;

  always #5 clk = ~clk;
  assign coin_seen = coin_ack | coin_force;

  change_payout #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .PULSE_LEN(PULSE_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
    .load(load), .load_tens(load_tens), .load_fives(load_fives),
    .eject_ten(eject_ten), .eject_five(eject_five), .coin_seen(coin_seen),
    .done(done), .err(err), .err_code(err_code), .paid(paid),
    .tens_left(tens_left), .fives_left(fives_left)
  );

  typedef struct {
    string name;
    int    is_err;
    int    code;
    int    paid;
    int    tens;
    int    fives;
    int    n_ten;
    int    n_five;
    int    lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic void check(string name, int act, int expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, expv);
    end
  endfunction

  function automatic exp_t mk(string n, int is_err, int code, int pd, int t, int f,
                              int nt, int nf, int lat);
    exp_t e;
    e.name = n; e.is_err = is_err; e.code = code; e.paid = pd; e.tens = t;
    e.fives = f; e.n_ten = nt; e.n_five = nf; e.lat = lat;
    return e;
  endfunction

  // Monitor: count pulses per request, check each done/err against the queue
  initial begin : monitor
    bit   prev_ready = 1'b1;
    bit   prev_ten = 1'b0;
    bit   prev_five = 1'b0;
    int   lat = 0;
    int   cnt_ten = 0;
    int   cnt_five = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        lat = 0; cnt_ten = 0; cnt_five = 0;
      end else begin
        if (prev_ready && !req_ready) begin
          lat = 1; cnt_ten = 0; cnt_five = 0;
        end else if (lat > 0) begin
          lat++;
        end
        if (eject_ten && !prev_ten) cnt_ten++;
        if (eject_five && !prev_five) cnt_five++;
        if (done || err) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: got done=%0b err=%0b, required no result",
                     done, err);
          end else begin
            e = sb.pop_front();
            check({e.name, "_err"}, int'(err), e.is_err);
            check({e.name, "_done"}, int'(done), 1 - e.is_err);
            check({e.name, "_err_code"}, int'(err_code), e.code);
            check({e.name, "_paid"}, int'(paid), e.paid);
            check({e.name, "_tens_left"}, int'(tens_left), e.tens);
            check({e.name, "_fives_left"}, int'(fives_left), e.fives);
            check({e.name, "_ten_pulses"}, cnt_ten, e.n_ten);
            check({e.name, "_five_pulses"}, cnt_five, e.n_five);
            if (e.lat >= 0) check({e.name, "_cycle"}, lat, e.lat);
            $display("txn %s: done=%0b err=%0b code=%0d paid=%0d tens=%0d fives=%0d pulses=%0d/%0d cycle=%0d",
                     e.name, done, err, err_code, paid, tens_left, fives_left,
                     cnt_ten, cnt_five, lat);
          end
        end
      end
      prev_ready = req_ready;
      prev_ten   = eject_ten;
      prev_five  = eject_five;
    end
  end

  // Chute sensor model: one coin_seen pulse two cycles after each eject pulse
  // ends, unless that pulse's bit in skip_mask is set.
  initial begin : responder
    int pulse_idx = 0;
    int ack_cnt = 0;
    bit prev_ej = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      coin_ack = 1'b0;
      if (req_valid) pulse_idx = 0;
      if (prev_ej && !(eject_ten || eject_five)) begin
        if (pulse_idx > 15 || !skip_mask[pulse_idx]) ack_cnt = 2;
        pulse_idx++;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) coin_ack = 1'b1;
      end
      prev_ej = eject_ten || eject_five;
    end
  end

  task automatic do_load(int t, int f);
    @(negedge clk);
    load = 1'b1; load_tens = CNT_W'(t); load_fives = CNT_W'(f);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic issue_raw(int amt);
    @(negedge clk);
    req_valid = 1'b1; req_amount = AMT_W'(amt);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic issue(int amt, exp_t e);
    sb.push_back(e);
    issue_raw(amt);
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 5000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: %0d results outstanding, required 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ten(bit level, string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (eject_ten == level) break;
      @(negedge clk);
    end
    if (i == 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_wait: eject_ten never reached %0b, required %0b", name, !level, level);
    end
  endtask

  initial begin : driver
    repeat (3) @(negedge clk);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_eject_ten", int'(eject_ten), 0);
    check("rst_eject_five", int'(eject_five), 0);
    check("rst_err_code", int'(err_code), 0);
    check("rst_paid", int'(paid), 0);
    check("rst_tens", int'(tens_left), 0);
    check("rst_fives", int'(fives_left), 0);
    rst = 1'b1;
    @(negedge clk);

    // 7 units = 3 tens + 1 five
    do_load(3, 2);
    skip_mask = 16'h0000;
    issue(7, mk("pay7", 0, 0, 7, 0, 1, 3, 1, -1));
    drain("pay7");

    // 4 units, no tens, only 3 fives: fault at first check
    do_load(0, 3);
    issue(4, mk("short", 1, 1, 0, 0, 3, 0, 0, 2));
    drain("short");

    // Ten hopper silent: falls back to four fives
    do_load(1, 5);
    skip_mask = 16'h0001;
    issue(4, mk("ten_timeout", 0, 0, 4, 0, 1, 1, 4, -1));
    drain("ten_timeout");

    // Second five never confirmed: jam
    do_load(0, 2);
    skip_mask = 16'h0002;
    issue(2, mk("five_jam", 1, 2, 1, 0, 0, 0, 2, -1));
    drain("five_jam");

    skip_mask = 16'h0000;
    issue(0, mk("zero", 0, 0, 0, 0, 0, 0, 0, 2));
    drain("zero");

    // coin_seen while idle changes nothing
    do_load(4, 4);
    @(negedge clk); coin_force = 1'b1;
    @(negedge clk); coin_force = 1'b0;
    @(negedge clk);
    check("idle_coin_ready", int'(req_ready), 1);
    check("idle_coin_tens", int'(tens_left), 4);
    check("idle_coin_fives", int'(fives_left), 4);
    check("idle_coin_paid", int'(paid), 0);
    $display("txn idle_coin: ready=%0b tens=%0d fives=%0d paid=%0d",
             req_ready, tens_left, fives_left, paid);

    // load during WAIT is ignored
    do_load(2, 0);
    issue(2, mk("load_in_wait", 0, 0, 2, 1, 0, 1, 0, -1));
    wait_ten(1'b1, "load_in_wait");
    wait_ten(1'b0, "load_in_wait");
    load = 1'b1; load_tens = 8'd9; load_fives = 8'd9;
    @(negedge clk);
    load = 1'b0;
    drain("load_in_wait");

    // Asynchronous reset mid-eject: pulse drops at once, request abandoned
    do_load(2, 0);
    issue_raw(2);
    wait_ten(1'b1, "rst_mid");
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_eject_ten", int'(eject_ten), 0);
    check("rst_mid_req_ready", int'(req_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_after_req_ready", int'(req_ready), 1);
    check("rst_after_tens", int'(tens_left), 0);
    check("rst_after_fives", int'(fives_left), 0);
    check("rst_after_paid", int'(paid), 0);
    $display("txn rst_mid: ready=%0b tens=%0d fives=%0d", req_ready, tens_left, fives_left);
    repeat (20) @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
